// File: rtl/pingpong_transposer.sv
// Double-buffered 4x4 transposer: fills one bank while draining the other, transposed or row-wise.
// Optional underfill detection is compiled in with TRANSPOSER_UNDERFILL_CHK_EN.
module pingpong_transposer #(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           sel,
    input  logic           dir,
    input  logic           rst_sync,
    input  logic [N*W-1:0] data_in,
    output logic [N*W-1:0] data_out,
    output logic           valid_out,
    output logic           err_underfill
);

    localparam logic [1:0] LAST = 2'(N - 1);

    logic [N*W-1:0] bank [2][N];
    logic [1:0]     full;
    logic [1:0]     ptr_q;
    logic           sel_q;

    logic           swap;
    logic [1:0]     p;
    logic           d;
    logic [N*W-1:0] word;

    always_comb begin
        swap = (sel != sel_q);
        p    = swap ? 2'd0 : ptr_q;
        d    = ~sel;
        word = '0;
        if (dir) begin
            word = bank[d][p];
        end else begin
            for (int k = 0; k < N; k++) begin
                word[k*W +: W] = bank[d][k][p*W +: W];
            end
        end
    end

    // Bank storage carries no reset; validity is tracked solely by full.
    always_ff @(posedge clk) begin
        if (en && !rst_sync) begin
            bank[sel][p] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            full      <= 2'b00;
            ptr_q     <= 2'd0;
            sel_q     <= 1'b1;
        end else begin
            sel_q <= sel;
            if (rst_sync) begin
                ptr_q     <= 2'd0;
                full      <= 2'b00;
                data_out  <= '0;
                valid_out <= 1'b0;
            end else if (en) begin
                data_out  <= full[d] ? word : '0;
                valid_out <= full[d];
                if (p == LAST) begin
                    full[sel] <= 1'b1;
                    full[d]   <= 1'b0;
                end
                ptr_q <= p + 2'd1;
            end else begin
                valid_out <= 1'b0;
                if (swap) begin
                    ptr_q <= 2'd0;
                end
            end
        end
    end

`ifdef TRANSPOSER_UNDERFILL_CHK_EN
    // wr_any: at least one row landed in the current fill bank since the last swap/restart.
    logic wr_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_any        <= 1'b0;
            err_underfill <= 1'b0;
        end else if (rst_sync) begin
            wr_any <= 1'b0;
        end else begin
            if (swap && wr_any && !full[sel_q]) begin
                err_underfill <= 1'b1;
            end
            if (en) begin
                wr_any <= 1'b1;
            end else if (swap) begin
                wr_any <= 1'b0;
            end
        end
    end
`else
    assign err_underfill = 1'b0;
`endif

endmodule

// File: tb/tb_pingpong_transposer.sv
// Directed scoreboard bench for pingpong_transposer (W=16, N=4).
module tb_pingpong_transposer;

    localparam int W = 16;
    localparam int N = 4;
`ifdef TRANSPOSER_UNDERFILL_CHK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic           sel;
    logic           dir;
    logic           rst_sync;
    logic [N*W-1:0] data_in;
    logic [N*W-1:0] data_out;
    logic           valid_out;
    logic           err_underfill;

    pingpong_transposer #(.W(W), .N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sel          (sel),
        .dir          (dir),
        .rst_sync     (rst_sync),
        .data_in      (data_in),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .err_underfill(err_underfill)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          tag;
        logic           v;
        logic [N*W-1:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [N*W-1:0] row_word(input int base, input int r);
        logic [N*W-1:0] w;
        for (int k = 0; k < N; k++) w[k*W +: W] = 16'(base + r*4 + k);
        return w;
    endfunction

    // Column p of the block whose row r lane k is base + r*4 + k.
    function automatic logic [N*W-1:0] transp(input int base, input int p);
        logic [N*W-1:0] w;
        for (int k = 0; k < N; k++) w[k*W +: W] = 16'(base + k*4 + p);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic e, input logic s, input logic dr,
                        input logic rs, input logic [N*W-1:0] din,
                        input logic ev, input logic [N*W-1:0] ed);
        exp_t x;
        en = e; sel = s; dir = dr; rst_sync = rs; data_in = din;
        sb.push_back('{tag, ev, ed});
        @(posedge clk);
        @(negedge clk);
        x = sb.pop_front();
        chk({x.tag, "_valid"}, {63'd0, valid_out}, {63'd0, x.v});
        chk({x.tag, "_data"}, data_out, x.d);
    endtask

    // Four enabled cycles writing block base_in while the other bank drains block db.
    task automatic group(input string tag, input logic s, input logic dr, input int base_in,
                         input logic dv, input int db);
        for (int p = 0; p < 4; p++) begin
            step($sformatf("%s%0d", tag, p), 1'b1, s, dr, 1'b0, row_word(base_in, p), dv,
                 dv ? (dr ? row_word(db, p) : transp(db, p)) : '0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; sel = 1'b1; dir = 1'b0; rst_sync = 1'b0; data_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_data", data_out, '0);
        chk("rst_valid", {63'd0, valid_out}, 64'd0);
        chk("rst_err", {63'd0, err_underfill}, 64'd0);
        rst_n = 1'b1;

        // Basic transpose, pass-through, continuous ping-pong: 16 words, 12 valid.
        group("fill", 1'b1, 1'b0, 'h00, 1'b0, 0);
        group("tr",   1'b0, 1'b0, 'h10, 1'b1, 'h00);
        group("pt",   1'b1, 1'b1, 'h20, 1'b1, 'h10);
        group("pp",   1'b0, 1'b0, 'h30, 1'b1, 'h20);

        // en gap mid-fill: data_out holds, valid drops, pointer frozen.
        step("gap_a0", 1'b1, 1'b1, 1'b0, 1'b0, row_word('h40, 0), 1'b1, transp('h30, 0));
        step("gap_a1", 1'b1, 1'b1, 1'b0, 1'b0, row_word('h40, 1), 1'b1, transp('h30, 1));
        for (int i = 0; i < 3; i++)
            step("gap_off", 1'b0, 1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, transp('h30, 1));
        step("gap_a2", 1'b1, 1'b1, 1'b0, 1'b0, row_word('h40, 2), 1'b1, transp('h30, 2));
        step("gap_a3", 1'b1, 1'b1, 1'b0, 1'b0, row_word('h40, 3), 1'b1, transp('h30, 3));
        group("gap_res", 1'b0, 1'b0, 'h50, 1'b1, 'h40);

        // rst_sync at drain row 2, then refill from pointer 0.
        step("rs_a0", 1'b1, 1'b1, 1'b0, 1'b0, row_word('h60, 0), 1'b1, transp('h50, 0));
        step("rs_a1", 1'b1, 1'b1, 1'b0, 1'b0, row_word('h60, 1), 1'b1, transp('h50, 1));
        step("rs_pulse", 1'b1, 1'b1, 1'b0, 1'b1, row_word('h60, 2), 1'b0, '0);
        group("rs_refill", 1'b1, 1'b0, 'h70, 1'b0, 0);
        group("rs_drain",  1'b0, 1'b0, 'h80, 1'b1, 'h70);
        chk("err_before_uf", {63'd0, err_underfill}, 64'd0);

        // Underfill: two rows into bank 1, then swap.
        step("uf_a0", 1'b1, 1'b1, 1'b0, 1'b0, row_word('h90, 0), 1'b1, transp('h80, 0));
        step("uf_a1", 1'b1, 1'b1, 1'b0, 1'b0, row_word('h90, 1), 1'b1, transp('h80, 1));
        step("uf_swap", 1'b1, 1'b0, 1'b0, 1'b0, row_word('hA0, 0), 1'b0, '0);
        chk("err_after_uf", {63'd0, err_underfill}, {63'd0, CHK});
        for (int p = 1; p < 4; p++)
            step("uf_nodrain", 1'b1, 1'b0, 1'b0, 1'b0, row_word('hA0, p), 1'b0, '0);
        step("uf_rs", 1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0, '0);
        chk("err_after_rs", {63'd0, err_underfill}, {63'd0, CHK});
        group("post_rs", 1'b0, 1'b0, 'hB0, 1'b0, 0);
        chk("err_sticky", {63'd0, err_underfill}, {63'd0, CHK});

        // Hard reset mid-operation.
        #2 rst_n = 1'b0;
        #1;
        chk("hrst_err", {63'd0, err_underfill}, 64'd0);
        chk("hrst_valid", {63'd0, valid_out}, 64'd0);
        chk("hrst_data", data_out, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
